// File: rtl/mult_sched_pkg.sv
// mult_sched_pkg: shared types, widths and parameter defaults for the multiplier scheduler.
package mult_sched_pkg;
    localparam int OP_W         = 8;
    localparam int PROD_W       = 16;
    localparam int NREQ_DEF     = 4;
    localparam int MULT_LAT_DEF = 2;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/mult8x8_core.sv
// mult8x8_core: unsigned 8x8 multiplier with LAT register stages and no handshake.
module mult8x8_core import mult_sched_pkg::*; #(
    parameter int LAT = MULT_LAT_DEF
) (
    input  logic              clk,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] p
);
    logic [PROD_W-1:0] pipe [LAT];

    always_ff @(posedge clk) begin
        pipe[0] <= PROD_W'(a) * PROD_W'(b);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign p = pipe[LAT-1];
endmodule

// File: rtl/mult_share_sched.sv
// mult_share_sched: round-robin arbiter time-sharing one pipelined 8x8 multiplier
// among NREQ requesters, one transaction in flight at a time.
module mult_share_sched import mult_sched_pkg::*; #(
    parameter int NREQ     = NREQ_DEF,
    parameter int MULT_LAT = MULT_LAT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [OP_W*NREQ-1:0]     req_a,
    input  logic [OP_W*NREQ-1:0]     req_b,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic [PROD_W-1:0]        rsp_p,
    output logic                     busy
);
    localparam int IDW = $clog2(NREQ);

    state_t            state, state_n;
    logic [3:0]        cnt;
    logic [IDW-1:0]    last_grant, win, cand;
    logic              any, accept;
    logic [OP_W-1:0]   win_a, win_b;
    logic [PROD_W-1:0] core_p;

    // Search starts just past the last winner so every requester gets a turn.
    always_comb begin
        any  = 1'b0;
        win  = '0;
        cand = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last_grant) + k) % NREQ);
            if (!any && req_valid[cand]) begin
                any = 1'b1;
                win = cand;
            end
        end
    end

    assign win_a     = req_a[win*OP_W +: OP_W];
    assign win_b     = req_b[win*OP_W +: OP_W];
    assign accept    = (state == IDLE) && any;
    assign rsp_valid = state == DONE;
    assign busy      = state != IDLE;

    always_comb begin
        state_n   = state;
        req_ready = '0;
        case (state)
            IDLE: if (any) begin
                req_ready[win] = 1'b1;
                state_n        = CALC;
            end
            CALC:    state_n = (cnt == 4'd1) ? DONE : CALC;
            DONE:    state_n = rsp_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            last_grant <= IDW'(NREQ - 1);
            rsp_id     <= '0;
            rsp_p      <= '0;
        end else if (accept) begin
            cnt        <= 4'(MULT_LAT);
            last_grant <= win;
            rsp_id     <= win;
        end else if (state == CALC) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) rsp_p <= core_p;
        end
    end

    // Core input is the live winner mux, so its first stage captures operands on the accept edge.
    mult8x8_core #(.LAT(MULT_LAT)) u_core (
        .clk (clk),
        .a   (win_a),
        .b   (win_b),
        .p   (core_p)
    );
endmodule
